int_ctrl: RTL

- Interrupt sequencer and CP0 register file for the 5-stage MIPS pipeline.
- Latches edge-triggered requests on three lines, masks and prioritises them, and picks a safe ID-stage slot to take one.
- On take: issues a PC redirect to the line's vector, a one-cycle flush of ID/EX, saves EPC and disables further interrupts.
- Handles eret, mtc0 and mfc0 for EPC (0x0e), disable (0x16), mask (0x17) and pending (0x18).

---
 rtl/int_ctrl_pkg.sv | 31 +++
 rtl/int_ctrl_irq_edge_latch.sv | 26 ++
 rtl/int_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared CP0 definitions for the interrupt sequencer: register numbers,
// FSM state encodings, default handler vectors and the priority pick.
package int_ctrl_pkg;

   localparam logic [4:0] CP0_EPC     = 5'h0e;
   localparam logic [4:0] CP0_DISABLE = 5'h16;
   localparam logic [4:0] CP0_MASK    = 5'h17;
   localparam logic [4:0] CP0_PENDING = 5'h18;
   localparam logic [4:0] CP0_CNT0    = 5'h19;
   localparam logic [4:0] CP0_CNT1    = 5'h1a;
   localparam logic [4:0] CP0_CNT2    = 5'h1b;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_DEFER   = 2'd1;
   localparam logic [1:0] ST_SERVICE = 2'd2;

   localparam logic [31:0] VEC0_DEF = 32'h0000_0800;
   localparam logic [31:0] VEC1_DEF = 32'h0000_0600;
   localparam logic [31:0] VEC2_DEF = 32'h0000_0400;

   // Highest-numbered eligible line wins; returns 0 when nothing is eligible.
   function automatic logic [1:0] irq_select(input logic [2:0] eligible);
      if (eligible[2])
         return 2'd2;
      else if (eligible[1])
         return 2'd1;
      else
         return 2'd0;
   endfunction

endpackage

// File: rtl/int_ctrl_irq_edge_latch.sv
// Rising-edge detector with a sticky pending bit per request line.
// A new edge in the same cycle as a clear keeps the bit set.
module irq_edge_latch #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] irq_in,
   input  logic [W-1:0] clr,
   output logic [W-1:0] pending
);

   logic [W-1:0] irq_prev;

   // Remember last sample and accumulate new rising edges.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_prev <= '0;
         pending  <= '0;
      end else begin
         irq_prev <= irq_in;
         pending  <= (pending & ~clr) | (irq_in & ~irq_prev);
      end
   end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt sequencer and CP0 register file for the 5-stage pipeline.
// Optional build macro INT_STATS_EN adds per-line 16-bit take counters
// at CP0 0x19..0x1b (mtc0 to one of them clears it).
//
// state      | meaning
// -----------+-----------------------------------------------------
// ST_IDLE    | nothing eligible, or the take cycle is being chosen
// ST_DEFER   | eligible request waiting for an unblocked ID slot
// ST_SERVICE | handler running, left on an accepted eret
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter logic [31:0] VEC0 = VEC0_DEF,
   parameter logic [31:0] VEC1 = VEC1_DEF,
   parameter logic [31:0] VEC2 = VEC2_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  irq_in,
   input  logic        pause_id,
   input  logic        pc_change_id,
   input  logic [31:0] pc_next_id,
   input  logic        ctr_eret_id,
   input  logic        ctr_mtc0_id,
   input  logic [4:0]  cp0_addr,
   input  logic [31:0] cp0_wdata,
   output logic [31:0] cp0_rdata,
   output logic        take_int,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic [31:0] epc,
   output logic        int_disable,
   output logic [2:0]  int_mask,
   output logic [2:0]  int_pending
);

   logic [1:0]  state, state_nxt;
   logic [2:0]  eligible, clr;
   logic [1:0]  sel;
   logic        blocked, eret_ok, mtc0_ok, take;
   logic [31:0] vec_sel;

   irq_edge_latch #(.W(3)) u_edge_latch (
      .clk     (clk),
      .rst     (rst),
      .irq_in  (irq_in),
      .clr     (clr),
      .pending (int_pending)
   );

   // Take decision and redirect; an accepted eret always beats a take.
   always_comb begin
      eligible = int_pending & int_mask & {3{~int_disable}};
      sel      = irq_select(eligible);
      blocked  = pause_id | pc_change_id | ctr_eret_id;
      eret_ok  = ctr_eret_id & ~pause_id;
      mtc0_ok  = ctr_mtc0_id & ~pause_id;
      take     = ~rst & (eligible != 3'b000) & ~blocked & ~eret_ok;
      clr      = take ? (3'b001 << sel) : 3'b000;
      case (sel)
         2'd2:    vec_sel = VEC2;
         2'd1:    vec_sel = VEC1;
         default: vec_sel = VEC0;
      endcase
      take_int    = take;
      pc_redirect = ~rst & (take | eret_ok);
      pc_target   = '0;
      if (!rst) begin
         if (eret_ok)
            pc_target = epc;
         else if (take)
            pc_target = vec_sel;
      end
   end

   // Sequencer next state.
   always_comb begin
      state_nxt = state;
      if (take) begin
         state_nxt = ST_SERVICE;
      end else begin
         case (state)
            ST_SERVICE: if (eret_ok) state_nxt = ST_IDLE;
            default:    state_nxt = (eligible != 3'b000) ? ST_DEFER : ST_IDLE;
         endcase
      end
   end

   // State and CP0 registers; take updates override a same-cycle mtc0.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         epc         <= '0;
         int_disable <= 1'b0;
         int_mask    <= 3'b000;
      end else begin
         state <= state_nxt;
         if (take)
            epc <= pc_next_id;
         else if (mtc0_ok && cp0_addr == CP0_EPC)
            epc <= cp0_wdata;
         if (take)
            int_disable <= 1'b1;
         else if (eret_ok)
            int_disable <= 1'b0;
         else if (mtc0_ok && cp0_addr == CP0_DISABLE)
            int_disable <= cp0_wdata[0];
         if (mtc0_ok && cp0_addr == CP0_MASK)
            int_mask <= cp0_wdata[2:0];
      end
   end

`ifdef INT_STATS_EN
   logic [15:0] irq_cnt [3];

   // Per-line take counters; a take of the same line beats an mtc0 clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) irq_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (take && sel == 2'(i))
               irq_cnt[i] <= irq_cnt[i] + 16'd1;
            else if (mtc0_ok && cp0_addr == CP0_CNT0 + 5'(i))
               irq_cnt[i] <= '0;
         end
      end
   end
`endif

   // mfc0 read mux.
   always_comb begin
      cp0_rdata = '0;
      case (cp0_addr)
         CP0_EPC:     cp0_rdata = epc;
         CP0_DISABLE: cp0_rdata = {31'b0, int_disable};
         CP0_MASK:    cp0_rdata = {29'b0, int_mask};
         CP0_PENDING: cp0_rdata = {29'b0, int_pending};
`ifdef INT_STATS_EN
         CP0_CNT0:    cp0_rdata = {16'b0, irq_cnt[0]};
         CP0_CNT1:    cp0_rdata = {16'b0, irq_cnt[1]};
         CP0_CNT2:    cp0_rdata = {16'b0, irq_cnt[2]};
`endif
         default:     cp0_rdata = '0;
      endcase
   end

endmodule
